// File: rtl/somador2comp_fd.sv
// somador2comp_fd: two's-complement adder datapath driven by per-step strobes.
// Each operation takes six strobes: load, magnitude, compare magnitudes,
// compare signs, add/subtract, and load result. Strobes that arrive out of
// order, or more than one strobe in a cycle, are rejected and raise the
// sticky seq_err flag.
// Optional macro SOMADOR2COMP_SUB_EN adds an 'op' input; op=1 selects A-B.
module somador2comp_fd #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         RESET_n,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
`ifdef SOMADOR2COMP_SUB_EN
    input  logic         op,
`endif
    input  logic         loadAB,
    input  logic         loadmagAB,
    input  logic         compmag,
    input  logic         compsigns,
    input  logic         add_sub,
    input  logic         loadres,
    output logic [W-1:0] R,
    output logic         ovf,
    output logic         valid,
    output logic         seq_err
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_COMPLETE
    } state_t;

    // Largest negative magnitude 2^(W-1), as a W+1 bit value.
    localparam logic [W:0] HALF = {1'b0, 1'b1, {(W-1){1'b0}}};

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic         sa_q, sa_d, sb_q, sb_d;
    logic [W-1:0] maga_q, maga_d, magb_q, magb_d;
    logic         ge_q, ge_d, eq_q, eq_d, same_q, same_d;
    logic [W:0]   mag_q, mag_d;
    logic         sign_q, sign_d;
    logic [W-1:0] r_q, r_d;
    logic         ovf_q, ovf_d, valid_q, valid_d, seq_err_q, seq_err_d;

    logic [5:0]   strobes;
    logic [5:0]   expected;
    logic         one_hot, accept, hold_done, violation;
    logic         sb_in;

    assign strobes = {loadres, add_sub, compsigns, compmag, loadmagAB, loadAB};
    assign one_hot = (strobes != '0) && ((strobes & (strobes - 6'd1)) == '0);

`ifdef SOMADOR2COMP_SUB_EN
    // Subtraction flips B's sign; zero stays positive so -0 never appears.
    assign sb_in = (B[W-1] ^ op) && (B != '0);
`else
    assign sb_in = B[W-1];
`endif

    // Decode which strobe the tracker expects and classify this cycle's strobes.
    always_comb begin
        expected = '0;
        case (state_q)
            ST_S1:   expected = 6'b000010;
            ST_S2:   expected = 6'b000100;
            ST_S3:   expected = 6'b001000;
            ST_S4:   expected = 6'b010000;
            ST_S5:   expected = 6'b100000;
            default: expected = '0;
        endcase
        accept    = !loadAB && one_hot && (strobes == expected);
        hold_done = (state_q == ST_COMPLETE) && (strobes == 6'b100000);
        if (loadAB)
            violation = (strobes[5:1] != '0);
        else
            violation = (strobes != '0) && !accept && !hold_done;
    end

    // Next-state logic of the step tracker.
    always_comb begin
        state_d = state_q;
        if (loadAB) begin
            state_d = ST_S1;
        end else if (accept) begin
            case (state_q)
                ST_S1:   state_d = ST_S2;
                ST_S2:   state_d = ST_S3;
                ST_S3:   state_d = ST_S4;
                ST_S4:   state_d = ST_S5;
                ST_S5:   state_d = ST_COMPLETE;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath: execute the accepted step, hold everything otherwise.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        maga_d    = maga_q;
        magb_d    = magb_q;
        ge_d      = ge_q;
        eq_d      = eq_q;
        same_d    = same_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        r_d       = r_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        seq_err_d = seq_err_q | violation;
        if (loadAB) begin
            a_d       = A;
            b_d       = B;
            sa_d      = A[W-1];
            sb_d      = sb_in;
            valid_d   = 1'b0;
            ovf_d     = 1'b0;
            seq_err_d = violation;
        end else if (accept) begin
            case (state_q)
                ST_S1: begin
                    // Magnitude uses B's own sign bit even when sb_q was flipped.
                    maga_d = a_q[W-1] ? -a_q : a_q;
                    magb_d = b_q[W-1] ? -b_q : b_q;
                end
                ST_S2: begin
                    ge_d = (maga_q >= magb_q);
                    eq_d = (maga_q == magb_q);
                end
                ST_S3: begin
                    same_d = (sa_q == sb_q);
                end
                ST_S4: begin
                    if (same_q) begin
                        mag_d  = {1'b0, maga_q} + {1'b0, magb_q};
                        sign_d = sa_q;
                    end else if (eq_q) begin
                        mag_d  = '0;
                        sign_d = 1'b0;
                    end else if (ge_q) begin
                        mag_d  = {1'b0, maga_q - magb_q};
                        sign_d = sa_q;
                    end else begin
                        mag_d  = {1'b0, magb_q - maga_q};
                        sign_d = sb_q;
                    end
                end
                ST_S5: begin
                    r_d     = sign_q ? -mag_q[W-1:0] : mag_q[W-1:0];
                    ovf_d   = sign_q ? (mag_q > HALF) : (mag_q >= HALF);
                    valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            maga_q    <= '0;
            magb_q    <= '0;
            ge_q      <= 1'b0;
            eq_q      <= 1'b0;
            same_q    <= 1'b0;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            r_q       <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            maga_q    <= maga_d;
            magb_q    <= magb_d;
            ge_q      <= ge_d;
            eq_q      <= eq_d;
            same_q    <= same_d;
            mag_q     <= mag_d;
            sign_q    <= sign_d;
            r_q       <= r_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            seq_err_q <= seq_err_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        R       = r_q;
        ovf     = ovf_q;
        valid   = valid_q;
        seq_err = seq_err_q;
    end

endmodule
